// File: rtl/gpio_ahb_sequencer.sv
// -----------------------------------------------------------------------------
// gpio_ahb_sequencer
//
// Purpose:
//   Single-master AHB-Lite sequencer that shares the AHBGPIO slave between two
//   command requesters (req0 = core side, req1 = debug/test side). Requests are
//   arbitrated round-robin and issued as one non-pipelined AHB-Lite transfer at
//   a time (address phase, then data phase). Completion and read data are
//   returned to the requester that owned the transfer.
//
// Optional feature (compile-time macro GPIO_SEQ_TIMEOUT_EN):
//   When defined, a data phase that sees HREADYOUT=0 for TIMEOUT_CYCLES cycles
//   is aborted and completed with rsp_err=1. When undefined, the data phase
//   waits indefinitely and rsp_err is tied low.
//
// Parameters:
//   ADDR_W          requester address width, zero-extended onto HADDR
//   BASE_ADDR       OR-ed onto the zero-extended address to form HADDR
//   TIMEOUT_CYCLES  data-phase wait limit (GPIO_SEQ_TIMEOUT_EN only)
//
// Ports:
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   reqN_valid/write/addr/wdata  command from requester N (held until ready)
//   reqN_ready                   command accepted this cycle (combinational)
//   rspN_valid                   one-cycle completion pulse for requester N
//   rsp_rdata, rsp_err           response payload, valid with rspN_valid
//   HSEL, HADDR, HTRANS, HWRITE,
//   HWDATA, HREADY               AHB-Lite master outputs to the slave
//   HREADYOUT, HRDATA            AHB-Lite slave responses
// -----------------------------------------------------------------------------
module gpio_ahb_sequencer #(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h5000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,

    output logic              HSEL,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [31:0]       HWDATA,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic [31:0]       HRDATA
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_RESP = 2'b11
    } state_t;

    state_t      state_q;
    logic        last_grant_q;   // ID of the most recently granted requester
    logic        gnt_id_q;       // owner of the transfer in flight
    logic [31:0] wdata_q;        // write data held for the data phase

    logic        gnt0_d;
    logic        gnt1_d;
    logic        accept_d;
    logic        sel_write_d;
    logic [31:0] sel_wdata_d;
    logic [31:0] sel_haddr_d;

`ifdef GPIO_SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q;
    logic       rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // The slave's HREADY input is a straight copy of its own HREADYOUT since
    // this master is the only one on the bus.
    assign HREADY = HREADYOUT;

    // Round-robin: a lone valid always wins; on a tie the requester that was
    // not granted last wins. last_grant_q resets to 1 so req0 wins first.
    assign gnt0_d   = req0_valid & (~req1_valid | last_grant_q);
    assign gnt1_d   = req1_valid & (~req0_valid | ~last_grant_q);
    assign accept_d = (state_q == S_IDLE) & (gnt0_d | gnt1_d);

    assign req0_ready = (state_q == S_IDLE) & gnt0_d;
    assign req1_ready = (state_q == S_IDLE) & gnt1_d;

    assign sel_write_d = gnt1_d ? req1_write : req0_write;
    assign sel_wdata_d = gnt1_d ? req1_wdata : req0_wdata;

    always_comb begin
        sel_haddr_d = '0;
        sel_haddr_d[ADDR_W-1:0] = gnt1_d ? req1_addr : req0_addr;
        sel_haddr_d = sel_haddr_d | BASE_ADDR;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            wdata_q      <= '0;
            HSEL         <= 1'b0;
            HADDR        <= '0;
            HTRANS       <= HTRANS_IDLE;
            HWRITE       <= 1'b0;
            HWDATA       <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_rdata    <= '0;
`ifdef GPIO_SEQ_TIMEOUT_EN
            wait_cnt_q   <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                // Idle: accept the granted command and launch its address
                // phase on the next cycle.
                S_IDLE: begin
                    if (accept_d) begin
                        gnt_id_q     <= gnt1_d;
                        last_grant_q <= gnt1_d;
                        wdata_q      <= sel_wdata_d;
                        HSEL         <= 1'b1;
                        HTRANS       <= HTRANS_NONSEQ;
                        HADDR        <= sel_haddr_d;
                        HWRITE       <= sel_write_d;
                        state_q      <= S_ADDR;
                    end
                end

                // Address phase is on the bus this cycle; the slave samples it
                // at this edge, so the data phase always follows.
                S_ADDR: begin
                    HSEL    <= 1'b0;
                    HTRANS  <= HTRANS_IDLE;
                    HWDATA  <= wdata_q;
                    state_q <= S_DATA;
`ifdef GPIO_SEQ_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end

                // Data phase: HWDATA/HWRITE stay stable until the slave is
                // ready. HWRITE still reflects the transfer direction here.
                S_DATA: begin
                    if (HREADYOUT) begin
                        if (!HWRITE) begin
                            rsp_rdata <= HRDATA;
                        end
                        rsp0_valid <= ~gnt_id_q;
                        rsp1_valid <= gnt_id_q;
                        state_q    <= S_RESP;
`ifdef GPIO_SEQ_TIMEOUT_EN
                        rsp_err_q  <= 1'b0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // This wait cycle is the TIMEOUT_CYCLES-th one; give
                        // up and report an error, leaving rsp_rdata untouched.
                        rsp0_valid <= ~gnt_id_q;
                        rsp1_valid <= gnt_id_q;
                        rsp_err_q  <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
`endif
                    end
                end

                // Response pulse is visible this cycle; retire it.
                S_RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
`ifdef GPIO_SEQ_TIMEOUT_EN
                    rsp_err_q  <= 1'b0;
`endif
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_ahb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gpio_ahb_sequencer
//
// Directed bench for gpio_ahb_sequencer. The bench plays the AHBGPIO slave by
// driving HREADYOUT/HRDATA directly. Inputs change 1 time unit after the rising
// edge; outputs are sampled 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_gpio_ahb_sequencer;

    logic        HCLK;
    logic        HRESET;
    logic        req0_valid, req0_write, req0_ready;
    logic [7:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_write, req1_ready;
    logic [7:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp0_valid, rsp1_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        HSEL, HWRITE, HREADY, HREADYOUT;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;

    int checks;
    int errors;

    gpio_ahb_sequencer #(
        .ADDR_W(8),
        .BASE_ADDR(32'h5000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .req0_valid(req0_valid),
        .req0_write(req0_write),
        .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_write(req1_write),
        .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid),
        .rsp1_valid(rsp1_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .HSEL(HSEL),
        .HADDR(HADDR),
        .HTRANS(HTRANS),
        .HWRITE(HWRITE),
        .HWDATA(HWDATA),
        .HREADY(HREADY),
        .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog sim time expired (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One complete zero-wait transfer from requester id, starting in an idle
    // cycle. exp_rd is the rsp_rdata value the response must show.
    task automatic do_xfer(input logic id, input logic wr, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input logic [31:0] exp_haddr, input logic [31:0] exp_rd,
                           input string tag);
        logic [31:0] oh;
        oh = id ? 32'd2 : 32'd1;
        if (id) begin
            req1_write = wr; req1_addr = a; req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_write = wr; req0_addr = a; req0_wdata = wd; req0_valid = 1'b1;
        end
        HRDATA = rd;
        #1;
        chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, oh);
        tick();                                   // T+1 address phase
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, "_hsel_a"}, {31'd0, HSEL}, 32'd1);
        chk({tag, "_htrans_a"}, {30'd0, HTRANS}, 32'd2);
        chk({tag, "_haddr"}, HADDR, exp_haddr);
        chk({tag, "_hwrite"}, {31'd0, HWRITE}, {31'd0, wr});
        chk({tag, "_ready_busy"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();                                   // T+2 data phase
        #1;
        chk({tag, "_htrans_d"}, {30'd0, HTRANS}, 32'd0);
        chk({tag, "_hsel_d"}, {31'd0, HSEL}, 32'd0);
        if (wr) chk({tag, "_hwdata"}, HWDATA, wd);
        chk({tag, "_rsp_early"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        tick();                                   // T+3 response
        #1;
        chk({tag, "_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, oh);
        chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        tick();                                   // T+4 idle again
        #1;
        chk({tag, "_rsp_done"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk({tag, "_rdata_hold"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        HRESET = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        HREADYOUT = 1'b1;
        HRDATA = '0;

        // Reset values
        tick();
        tick();
        #1;
        chk("rst_hsel", {31'd0, HSEL}, 32'd0);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        HREADYOUT = 1'b0;
        #1;
        chk("rst_hready_lo", {31'd0, HREADY}, 32'd0);
        HREADYOUT = 1'b1;
        #1;
        chk("rst_hready_hi", {31'd0, HREADY}, 32'd1);
        tick();
        HRESET = 1'b0;
        tick();

        // Single write from req0
        do_xfer(1'b0, 1'b1, 8'h04, 32'h0000_00FF, 32'hFFFF_FFFF,
                32'h5000_0004, 32'h0000_0000, "wr0");

        // Write then read from req1; the write leaves rsp_rdata untouched
        do_xfer(1'b1, 1'b1, 8'h04, 32'h0000_A5A5, 32'hFFFF_FFFF,
                32'h5000_0004, 32'h0000_0000, "wr1");
        do_xfer(1'b1, 1'b0, 8'h00, 32'h0000_0000, 32'h0000_1234,
                32'h5000_0000, 32'h0000_1234, "rd1");

        // Contention: both valid for 16 cycles -> grants 0,1,0,1
        req0_write = 1'b1; req0_addr = 8'h08; req0_wdata = 32'h0000_0011;
        req1_write = 1'b1; req1_addr = 8'h0C; req1_wdata = 32'h0000_0022;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] own_oh;
            if (i > 0) tick();
            #1;
            own_oh = (((i / 4) % 2) == 1) ? 32'd2 : 32'd1;
            chk("rr_ready", {30'd0, req1_ready, req0_ready},
                ((i % 4) == 0) ? own_oh : 32'd0);
            chk("rr_rsp", {30'd0, rsp1_valid, rsp0_valid},
                ((i % 4) == 3) ? own_oh : 32'd0);
            if ((i % 4) == 1)
                chk("rr_haddr", HADDR, (own_oh == 32'd2) ? 32'h5000_000C : 32'h5000_0008);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Wait states: 3 cycles of HREADYOUT=0 with req1 pending
        req0_write = 1'b1; req0_addr = 8'h10; req0_wdata = 32'hDEAD_BEEF;
        req0_valid = 1'b1;
        #1;
        chk("ws_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();                                   // T+1
        req0_valid = 1'b0;
        tick();                                   // T+2
        HREADYOUT = 1'b0;
        req1_write = 1'b0; req1_addr = 8'h00; req1_valid = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            if (j == 5) HREADYOUT = 1'b1;
            #1;
            chk("ws_hwdata", HWDATA, 32'hDEAD_BEEF);
            chk("ws_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            chk("ws_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        #1;                                       // T+6
        chk("ws_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
        chk("ws_rdata", rsp_rdata, 32'h0000_1234);
        chk("ws_resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();                                   // T+7
        req1_valid = 1'b0;
        #1;
        chk("ws_rsp_done", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

        // Reset in the middle of a data phase
        tick();
        req0_write = 1'b0; req0_addr = 8'h00; req0_valid = 1'b1;
        HRDATA = 32'hCAFE_F00D;
        #1;
        chk("mr_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        HREADYOUT = 1'b0;
        #1;
        HRESET = 1'b1;
        #1;
        chk("mr_hsel", {31'd0, HSEL}, 32'd0);
        chk("mr_htrans", {30'd0, HTRANS}, 32'd0);
        chk("mr_haddr", HADDR, 32'd0);
        chk("mr_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("mr_hwdata", HWDATA, 32'd0);
        chk("mr_rdata", rsp_rdata, 32'd0);
        chk("mr_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("mr_hready", {31'd0, HREADY}, 32'd0);
        tick();
        tick();
        HRESET = 1'b0;
        HREADYOUT = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("mr_quiet_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            chk("mr_quiet_hsel", {31'd0, HSEL}, 32'd0);
        end
        // First tie after reset goes to req0
        req1_write = 1'b1; req1_addr = 8'h0C; req1_wdata = 32'h0000_0099;
        req1_valid = 1'b1;
        do_xfer(1'b0, 1'b1, 8'h04, 32'h0000_0055, 32'hFFFF_FFFF,
                32'h5000_0004, 32'h0000_0000, "post_rst");

`ifdef GPIO_SEQ_TIMEOUT_EN
        // Timeout: slave never ready -> error response after 16 wait cycles
        req0_write = 1'b0; req0_addr = 8'h00; req0_valid = 1'b1;
        HRDATA = 32'h1111_2222;
        #1;
        chk("to_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();                                   // T+2
        HREADYOUT = 1'b0;
        for (int m = 2; m <= 17; m++) begin
            #1;
            chk("to_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            tick();
        end
        #1;                                       // T+18
        chk("to_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
        chk("to_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rdata", rsp_rdata, 32'd0);
        tick();
        HREADYOUT = 1'b1;
        do_xfer(1'b0, 1'b1, 8'h08, 32'h0000_0077, 32'hFFFF_FFFF,
                32'h5000_0008, 32'h0000_0000, "to_after");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
